// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction fetch stage with a small prefetch FIFO.
// It decouples PC issue to a 1-cycle-latency program memory from the IF/ID register.
//
// Ports:
//   i_clock, i_reset        clock (rising edge), asynchronous active-high reset
//   i_valid, i_stall        global enable, decode stall
//   i_pc_src, i_pc_next     redirect request and its target
//   o_imem_addr, o_imem_req program memory read address and read request
//   i_imem_data             read data, valid the cycle after o_imem_req
//   o_valid, o_pc_next      IF/ID valid flag and instruction PC
//   o_instruction, o_rs,    fetched instruction and its rs/rt fields
//   o_rt
//   o_halt                  sticky halt flag
//
// Optional feature: define FETCH_HALT_EN to enable all-ones halt detection.
// When it is undefined, o_halt is tied to 0.
module fetch_prefetch_unit #(
    parameter int NB_DATA     = 32,
    parameter int NB_REGISTER = 5,
    parameter int NB_ADDR     = 11,
    parameter int FIFO_DEPTH  = 4,
    parameter int PC_STEP     = 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_stall,
    input  logic                   i_pc_src,
    input  logic [NB_DATA-1:0]     i_pc_next,
    output logic [NB_ADDR-1:0]     o_imem_addr,
    output logic                   o_imem_req,
    input  logic [NB_DATA-1:0]     i_imem_data,
    output logic                   o_valid,
    output logic [NB_DATA-1:0]     o_pc_next,
    output logic [NB_DATA-1:0]     o_instruction,
    output logic [NB_REGISTER-1:0] o_rs,
    output logic [NB_REGISTER-1:0] o_rt,
    output logic                   o_halt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    logic [NB_DATA-1:0] r_pc;
    logic [NB_DATA-1:0] r_inflight_pc;
    logic               r_inflight;

    logic [NB_DATA-1:0] r_fifo_pc  [FIFO_DEPTH];
    logic [NB_DATA-1:0] r_fifo_ins [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               r_valid;
    logic [NB_DATA-1:0] r_out_pc;
    logic [NB_DATA-1:0] r_out_ins;

    logic               w_redirect;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_halt;
    logic [CNT_W:0]     w_used;

    // Queued entries plus the outstanding read form the issue credit,
    // so a captured response always finds a free FIFO slot.
    assign w_used     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_redirect = i_valid & i_pc_src;
    assign w_req      = ~i_reset & i_valid & ~i_pc_src & ~w_halt
                      & (w_used < DEPTH_C);
    // Capture ignores i_valid so that no response is lost while frozen.
    assign w_push     = r_inflight & ~w_redirect;
    assign w_pop      = i_valid & ~i_pc_src & ~i_stall & ~w_halt
                      & (r_count != '0);

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc[NB_ADDR-1:0];

    // PC generation and in-flight tracking
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pc          <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_pc <= r_pc;
            end
            if (w_redirect) begin
                r_pc <= i_pc_next;
            end else if (w_req) begin
                r_pc <= r_pc + NB_DATA'(PC_STEP);
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage holds data only, so it needs no reset
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]  <= r_inflight_pc;
            r_fifo_ins[r_wr_ptr] <= i_imem_data;
        end
    end

`ifdef FETCH_HALT_EN
    logic r_halt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_halt <= 1'b0;
        end else if (w_pop && (r_fifo_ins[r_rd_ptr] == '1)) begin
            r_halt <= 1'b1;
        end
    end

    assign w_halt = r_halt;
`else
    assign w_halt = 1'b0;
`endif

    assign o_halt = w_halt;

    // IF/ID output register; on an empty FIFO only o_valid drops
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_valid   <= 1'b0;
            r_out_pc  <= '0;
            r_out_ins <= '0;
        end else if (w_redirect) begin
            r_valid <= 1'b0;
        end else if (i_valid && !i_stall) begin
            if (w_pop) begin
                r_valid   <= 1'b1;
                r_out_pc  <= r_fifo_pc[r_rd_ptr];
                r_out_ins <= r_fifo_ins[r_rd_ptr];
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid       = r_valid;
    assign o_pc_next     = r_out_pc;
    assign o_instruction = r_out_ins;
    assign o_rs          = r_out_ins[21 +: NB_REGISTER];
    assign o_rt          = r_out_ins[16 +: NB_REGISTER];

endmodule
